// File: rtl/sonar_pkg.sv
// Shared sonar front-end definitions: transmit FSM states and clock/carrier constants.
package sonar_pkg;

    localparam int SONAR_CLK_HZ      = 20480000;
    localparam int SONAR_TX_HZ       = 40000;
    localparam int SONAR_HALF_PERIOD = SONAR_CLK_HZ / (2 * SONAR_TX_HZ);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PH_P   = 3'd1,
        DEAD_P = 3'd2,
        PH_N   = 3'd3,
        DEAD_N = 3'd4,
        RING   = 3'd5,
        FIN    = 3'd6
    } sonar_tx_state_t;

endpackage

// File: rtl/sonar_burst_tx.sv
// Counted, dead-time-protected 40 kHz transducer burst with receiver blanking.
// Optional ringdown blanking after the burst is built when SONAR_TX_RINGDOWN_EN is defined.
module sonar_burst_tx
    import sonar_pkg::*;
#(
    parameter int HALF_PERIOD = SONAR_HALF_PERIOD,
    parameter int DEAD_TIME   = 4,
    parameter int CNT_W       = 8,
    parameter int RINGDOWN    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_cycles,
    input  logic             abort,
    output logic             drive_p,
    output logic             drive_n,
    output logic             busy,
    output logic             blank,
    output logic             done
);

    localparam int TMR_W = $clog2(HALF_PERIOD) + 1;
    localparam logic [TMR_W-1:0] PH_LOAD   = TMR_W'(HALF_PERIOD - DEAD_TIME - 1);
    localparam logic [TMR_W-1:0] DEAD_LOAD = TMR_W'(DEAD_TIME - 1);

    if (DEAD_TIME < 1 || DEAD_TIME >= HALF_PERIOD || RINGDOWN < 1) begin : g_bad_param
        $error("sonar_burst_tx: illegal DEAD_TIME/HALF_PERIOD/RINGDOWN");
    end

    sonar_tx_state_t  state, state_next;
    logic [TMR_W-1:0] tmr, tmr_next;
    logic [CNT_W-1:0] cyc, cyc_next;
    logic             drive_p_next, drive_n_next, busy_next, done_next;

`ifdef SONAR_TX_RINGDOWN_EN
    localparam int RING_W = $clog2(RINGDOWN) + 1;
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RINGDOWN - 1);
    logic [RING_W-1:0] ring_cnt, ring_next;
`endif

    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        cyc_next   = cyc;
`ifdef SONAR_TX_RINGDOWN_EN
        ring_next  = ring_cnt;
`endif
        case (state)
            IDLE: begin
                if (start && !abort && burst_cycles != '0) begin
                    state_next = PH_P;
                    tmr_next   = PH_LOAD;
                    cyc_next   = burst_cycles;
                end
            end
            PH_P: begin
                if (tmr == '0) begin
                    state_next = DEAD_P;
                    tmr_next   = DEAD_LOAD;
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            DEAD_P: begin
                if (tmr == '0) begin
                    state_next = PH_N;
                    tmr_next   = PH_LOAD;
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            PH_N: begin
                if (tmr == '0) begin
                    state_next = DEAD_N;
                    tmr_next   = DEAD_LOAD;
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            DEAD_N: begin
                if (tmr == '0) begin
                    cyc_next = cyc - CNT_W'(1);
                    if (cyc == CNT_W'(1)) begin
`ifdef SONAR_TX_RINGDOWN_EN
                        state_next = RING;
                        ring_next  = RING_LOAD;
`else
                        state_next = FIN;
`endif
                        tmr_next = '0;
                    end else begin
                        state_next = PH_P;
                        tmr_next   = PH_LOAD;
                    end
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
`ifdef SONAR_TX_RINGDOWN_EN
            RING: begin
                if (ring_cnt == '0) begin
                    state_next = FIN;
                end else begin
                    ring_next = ring_cnt - RING_W'(1);
                end
            end
`endif
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Abort overrides every transition; the IDLE case above already drops start.
        if (abort && state != IDLE) begin
            state_next = IDLE;
            tmr_next   = '0;
            cyc_next   = '0;
`ifdef SONAR_TX_RINGDOWN_EN
            ring_next  = '0;
`endif
        end
    end

    // Outputs are registered decodes of the next state, so they line up with the state register.
    always_comb begin
        drive_p_next = (state_next == PH_P);
        drive_n_next = (state_next == PH_N);
        busy_next    = (state_next == PH_P) || (state_next == DEAD_P) ||
                       (state_next == PH_N) || (state_next == DEAD_N) ||
                       (state_next == RING);
        done_next    = (state_next == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmr     <= '0;
            cyc     <= '0;
            drive_p <= 1'b0;
            drive_n <= 1'b0;
            busy    <= 1'b0;
            blank   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            tmr     <= tmr_next;
            cyc     <= cyc_next;
            drive_p <= drive_p_next;
            drive_n <= drive_n_next;
            busy    <= busy_next;
            blank   <= busy_next;
            done    <= done_next;
        end
    end

`ifdef SONAR_TX_RINGDOWN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_cnt <= '0;
        end else begin
            ring_cnt <= ring_next;
        end
    end
`endif

endmodule

// File: tb/tb_sonar_burst_tx.sv
// Directed bench for sonar_burst_tx: table of bursts plus abort, reset and short-period sweep sequences.
module tb_sonar_burst_tx;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] burst_cycles;
    logic       drive_p, drive_n, busy, blank, done;

    logic       start2, abort2;
    logic [7:0] burst_cycles2;
    logic       drive_p2, drive_n2, busy2, blank2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sonar_burst_tx dut (
        .clk(clk), .rst(rst), .start(start), .burst_cycles(burst_cycles), .abort(abort),
        .drive_p(drive_p), .drive_n(drive_n), .busy(busy), .blank(blank), .done(done)
    );

    sonar_burst_tx #(.HALF_PERIOD(16), .DEAD_TIME(1), .CNT_W(8), .RINGDOWN(1024)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .burst_cycles(burst_cycles2), .abort(abort2),
        .drive_p(drive_p2), .drive_n(drive_n2), .busy(busy2), .blank(blank2), .done(done2)
    );

    typedef struct {
        int n;
        int inj;
        int exp_busy;
        int exp_p;
        int exp_n;
        int exp_dead;
        int exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Starts a burst and watches it to completion, counting per-output cycles.
    task automatic run_burst(input vec_t v, input string tag);
        int busy_c = 0, p_c = 0, n_c = 0, dead_c = 0, done_c = 0;
        int overlap = 0, blank_bad = 0, run_bad = 0, p_run = 0, n_run = 0;
        int limit;
        limit = v.exp_busy + 20;
        @(negedge clk);
        burst_cycles = 8'(v.n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_latency"}, int'(drive_p), (v.exp_busy != 0) ? 1 : 0);
        for (int c = 0; c < limit; c++) begin
            if (c > 0) @(negedge clk);
            if (busy) busy_c++;
            if (drive_p) p_c++;
            if (drive_n) n_c++;
            if (busy && !drive_p && !drive_n) dead_c++;
            if (drive_p && drive_n) overlap++;
            if (blank != busy) blank_bad++;
            if (drive_p) p_run++;
            else begin
                if (p_run != 0 && p_run != 252) run_bad++;
                p_run = 0;
            end
            if (drive_n) n_run++;
            else begin
                if (n_run != 0 && n_run != 252) run_bad++;
                n_run = 0;
            end
            if (c == v.inj) begin
                start = 1'b1;
                burst_cycles = 8'd8;
            end else if (c == v.inj + 1) begin
                start = 1'b0;
            end
            if (done) begin
                done_c++;
                if (busy) overlap++;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, busy_c, v.exp_busy);
        chk({tag, "_p_cycles"}, p_c, v.exp_p);
        chk({tag, "_n_cycles"}, n_c, v.exp_n);
        chk({tag, "_dead_cycles"}, dead_c, v.exp_dead);
        chk({tag, "_done"}, done_c, v.exp_done);
        chk({tag, "_overlap"}, overlap, 0);
        chk({tag, "_blank_eq_busy"}, blank_bad, 0);
        chk({tag, "_run_len"}, run_bad, 0);
        @(negedge clk);
        chk({tag, "_idle_after"}, int'({busy, blank, done, drive_p, drive_n}), 0);
    endtask

    initial begin
        int busy_c, p_c, dead_c, done_c, overlap, seen;

        vecs[0] = '{n: 1, inj: -1, exp_busy: 512,  exp_p: 252,  exp_n: 252,  exp_dead: 8,  exp_done: 1};
        vecs[1] = '{n: 2, inj: -1, exp_busy: 1024, exp_p: 504,  exp_n: 504,  exp_dead: 16, exp_done: 1};
        vecs[2] = '{n: 8, inj: -1, exp_busy: 4096, exp_p: 2016, exp_n: 2016, exp_dead: 64, exp_done: 1};
        vecs[3] = '{n: 0, inj: -1, exp_busy: 0,    exp_p: 0,    exp_n: 0,    exp_dead: 0,  exp_done: 0};
        vecs[4] = '{n: 3, inj: -1, exp_busy: 1536, exp_p: 756,  exp_n: 756,  exp_dead: 24, exp_done: 1};
        vecs[5] = '{n: 2, inj: 100, exp_busy: 1024, exp_p: 504, exp_n: 504,  exp_dead: 16, exp_done: 1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; burst_cycles = 8'd0;
        start2 = 1'b0; abort2 = 1'b0; burst_cycles2 = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({drive_p, drive_n, busy, blank, done}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", int'({drive_p, drive_n, busy, blank, done}), 0);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort at cycle 300 of an 8-period burst lands in PH_N.
        @(negedge clk);
        burst_cycles = 8'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        chk("pre_abort_drive_n", int'(drive_n), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outputs", int'({drive_p, drive_n, busy, blank, done}), 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);
        run_burst(vecs[2], "after_abort");

        // Abort together with start in IDLE drops the start.
        @(negedge clk);
        burst_cycles = 8'd4;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", int'({busy, drive_p}), 0);

        // Reset during PH_P.
        @(negedge clk);
        burst_cycles = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("pre_reset_drive_p", int'(drive_p), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_drive_p", int'(drive_p), 0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (drive_p || drive_n || busy || blank || done) seen++;
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (drive_p || drive_n || busy || blank || done) seen++;
        end
        chk("reset_hold_quiet", seen, 0);

        // Short-period instance: 255 periods of 32 cycles.
        @(negedge clk);
        burst_cycles2 = 8'd255;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        busy_c = 0; p_c = 0; dead_c = 0; done_c = 0; overlap = 0;
        for (int c = 0; c < 8300; c++) begin
            if (c > 0) @(negedge clk);
            if (busy2) busy_c++;
            if (drive_p2) p_c++;
            if (busy2 && !drive_p2 && !drive_n2) dead_c++;
            if (drive_p2 && drive_n2) overlap++;
            if (done2) begin
                done_c++;
                break;
            end
        end
        chk("sweep_busy_cycles", busy_c, 8160);
        chk("sweep_p_cycles", p_c, 3825);
        chk("sweep_dead_cycles", dead_c, 510);
        chk("sweep_overlap", overlap, 0);
        chk("sweep_done", done_c, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
